mutative_line_adapter: RTL and testbench

MUTATIVE_LINE_ADAPTER -- requirements
Module: mutative_line_adapter

---
 rtl/mutative_line_adapter_pkg.sv | 26 ++
 rtl/mutative_line_adapter_beat_buffer.sv | 34 +++
 rtl/mutative_line_adapter.sv | 172 +++++++++++++++++
 tb/tb_mutative_line_adapter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mutative_line_adapter_pkg.sv
// Shared types and constants for the cache-line to burst-memory adapter.
// Package mutative_types: beat/line geometry, FSM state enum, address helper.
package mutative_types;

  localparam int ADDR_WIDTH    = 32;
  localparam int BEAT_WIDTH    = 64;
  localparam int BURST_BEATS   = 4;
  localparam int LINE_WIDTH    = BEAT_WIDTH * BURST_BEATS;
  localparam int BEAT_IDX_W    = 2;
  localparam int CNT_WIDTH     = 32;
  localparam logic [ADDR_WIDTH-1:0] LINE_OFFSET_MASK = 32'h0000_001F;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } line_adapter_state_t;

  // Clear the byte-in-line offset so bursts always start on a line boundary.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/mutative_line_adapter_beat_buffer.sv
// mutative_beat_buffer: holds one cache line; parallel load of the whole line,
// beat-indexed 64-bit write, and beat-indexed 64-bit combinational read.
module mutative_beat_buffer
  import mutative_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  wr_en_i,
  input  logic [BEAT_IDX_W-1:0] wr_idx_i,
  input  logic [BEAT_WIDTH-1:0] wr_beat_i,
  input  logic [BEAT_IDX_W-1:0] rd_idx_i,
  output logic [BEAT_WIDTH-1:0] rd_beat_o,
  output logic [LINE_WIDTH-1:0] line_o
);

  logic [LINE_WIDTH-1:0] line_q;

  // Line storage: whole-line load takes priority over a single-beat write.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= line_i;
    end else if (wr_en_i) begin
      line_q[wr_idx_i*BEAT_WIDTH +: BEAT_WIDTH] <= wr_beat_i;
    end
  end

  assign rd_beat_o = line_q[rd_idx_i*BEAT_WIDTH +: BEAT_WIDTH];
  assign line_o    = line_q;

endmodule

// File: rtl/mutative_line_adapter.sv
// mutative_line_adapter: turns one 256-bit cache line request into a 4-beat
// 64-bit burst on the memory side.
// Optional feature macro: ADAPTER_PERF_CNT_EN enables the completed-line
// read/write counters; without it the counter ports are tied to zero.
//
// Handshakes: a memory command (bmem_read) or write beat (bmem_write/bmem_wdata)
// is transferred on a cycle where it is high and bmem_ready=1; until then it is
// held stable. Read beats have no back-pressure: each cycle with bmem_rvalid=1
// in RD_DATA delivers one beat. dfp_read/dfp_write are held by the requester
// until the single-cycle dfp_resp pulse.
module mutative_line_adapter
  import mutative_types::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   dfp_addr,
  input  logic                    dfp_read,
  input  logic                    dfp_write,
  input  logic [LINE_WIDTH-1:0]   dfp_wdata,
  output logic [LINE_WIDTH-1:0]   dfp_rdata,
  output logic                    dfp_resp,
  output logic [ADDR_WIDTH-1:0]   bmem_addr,
  output logic                    bmem_read,
  output logic                    bmem_write,
  output logic [BEAT_WIDTH-1:0]   bmem_wdata,
  input  logic                    bmem_ready,
  input  logic [BEAT_WIDTH-1:0]   bmem_rdata,
  input  logic                    bmem_rvalid,
  output logic [CNT_WIDTH-1:0]    rd_line_cnt,
  output logic [CNT_WIDTH-1:0]    wr_line_cnt,
  output line_adapter_state_t     dbg_state
);

  line_adapter_state_t   state_q;
  logic [BEAT_IDX_W-1:0] beat_q;
  logic [BEAT_IDX_W-1:0] next_beat_d;
  logic                  resp_q;
  logic                  bmem_read_q;
  logic                  bmem_write_q;
  logic [BEAT_WIDTH-1:0] bmem_wdata_q;
  logic [ADDR_WIDTH-1:0] bmem_addr_q;

  logic                  buf_load_d;
  logic                  buf_wr_d;
  logic [BEAT_WIDTH-1:0] buf_rd_beat;
  logic [LINE_WIDTH-1:0] buf_line;

  // Buffer control: load the write line when a write is sampled, store read
  // beats only while a read burst is in its data phase.
  always_comb begin
    buf_load_d  = (state_q == IDLE) && dfp_write;
    buf_wr_d    = (state_q == RD_DATA) && bmem_rvalid;
    next_beat_d = beat_q + 2'd1;
  end

  mutative_beat_buffer u_beat_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load_d),
    .line_i    (dfp_wdata),
    .wr_en_i   (buf_wr_d),
    .wr_idx_i  (beat_q),
    .wr_beat_i (bmem_rdata),
    .rd_idx_i  (next_beat_d),
    .rd_beat_o (buf_rd_beat),
    .line_o    (buf_line)
  );

  // Main FSM with registered outputs; the next write beat is prefetched from
  // the buffer so bmem_wdata is ready the cycle after each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      resp_q       <= 1'b0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
      bmem_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dfp_write) begin
            state_q      <= WR_DATA;
            bmem_addr_q  <= line_align(dfp_addr);
            bmem_write_q <= 1'b1;
            bmem_wdata_q <= dfp_wdata[BEAT_WIDTH-1:0];
          end else if (dfp_read) begin
            state_q     <= RD_REQ;
            bmem_addr_q <= line_align(dfp_addr);
            bmem_read_q <= 1'b1;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read_q <= 1'b0;
            state_q     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bmem_rvalid) begin
            beat_q <= next_beat_d;
            if (beat_q == 2'd3) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (bmem_ready) begin
            beat_q <= next_beat_d;
            if (beat_q == 2'd3) begin
              bmem_write_q <= 1'b0;
              state_q      <= RESP;
              resp_q       <= 1'b1;
            end else begin
              bmem_wdata_q <= buf_rd_beat;
            end
          end
        end
        RESP: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dfp_resp   = resp_q;
  assign dfp_rdata  = buf_line;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;
  assign dbg_state  = state_q;

`ifdef ADAPTER_PERF_CNT_EN
  logic                 op_wr_q;
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;

  // Remember the kind of transaction so RESP credits the right counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr_q <= 1'b0;
    end else if ((state_q == IDLE) && (dfp_write || dfp_read)) begin
      op_wr_q <= dfp_write;
    end
  end

  // Completed-line counters, one increment per RESP, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (op_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else         rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_line_cnt = rd_cnt_q;
  assign wr_line_cnt = wr_cnt_q;
`else
  assign rd_line_cnt = '0;
  assign wr_line_cnt = '0;
`endif

endmodule

// File: tb/tb_mutative_line_adapter.sv
// Testbench for mutative_line_adapter: directed latency/corner scenarios plus
// randomized line transactions against a transaction-level memory model.
module tb_mutative_line_adapter;
  import mutative_types::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic [31:0]  rd_line_cnt;
  logic [31:0]  wr_line_cnt;
  line_adapter_state_t dbg_state;

  mutative_line_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .rd_line_cnt (rd_line_cnt),
    .wr_line_cnt (wr_line_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  int model_rd = 0;
  int model_wr = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef ADAPTER_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Runs one line transaction starting in the current cycle (cycle 0, DUT idle).
  // Acts as the requester and as burst memory; returns the dfp_resp cycle and
  // the cycle of the first accepted write beat. stall_beat>=0 holds ready low
  // for 3 cycles while that write beat is presented.
  task automatic run_txn(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [255:0] rline,
                         input int ready_pct, input int rvalid_pct, input int stall_beat,
                         output int resp_cycle, output int first_beat_cycle);
    logic [31:0] exp_addr;
    bit is_wr;
    bit rd_acc;
    bit saw_read;
    bit done;
    int beats_sent;
    int beats_acc;
    int stall_left;
    exp_addr   = addr - (addr % 32);
    is_wr      = do_wr;
    rd_acc     = 0;
    saw_read   = 0;
    done       = 0;
    beats_sent = 0;
    beats_acc  = 0;
    stall_left = (stall_beat >= 0) ? 3 : 0;
    resp_cycle = -1;
    first_beat_cycle = -1;
    exp_q.delete();
    if (is_wr) for (int k = 0; k < 4; k++) exp_q.push_back(wdata[k*64 +: 64]);

    dfp_addr    = addr;
    dfp_read    = do_rd;
    dfp_write   = do_wr;
    dfp_wdata   = wdata;
    bmem_ready  = 1'b1;
    bmem_rvalid = 1'($urandom_range(0, 1));
    bmem_rdata  = {$urandom, $urandom};

    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      step();
      // Request fields may wander mid-burst; the adapter must keep its latch.
      dfp_addr  = $urandom;
      dfp_wdata = rand_line();
      if (is_wr && stall_beat == beats_acc && stall_left > 0) begin
        bmem_ready = 1'b0;
        stall_left--;
      end else begin
        bmem_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      if (rd_acc && beats_sent < 4 && $urandom_range(1, 100) <= rvalid_pct) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = rline[beats_sent*64 +: 64];
        beats_sent++;
      end else if (!rd_acc && $urandom_range(0, 2) == 0) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = {$urandom, $urandom};
      end else begin
        bmem_rvalid = 1'b0;
        bmem_rdata  = {$urandom, $urandom};
      end

      check("rd_wr_exclusive", 256'(bmem_read & bmem_write), 256'(0));
      if (bmem_read) begin
        saw_read = 1;
        check("rd_addr", 256'(bmem_addr), 256'(exp_addr));
        if (bmem_ready) rd_acc = 1;
      end
      if (bmem_write) begin
        check("wr_addr", 256'(bmem_addr), 256'(exp_addr));
        if (exp_q.size() == 0) begin
          check("wr_extra_beat", 256'(1), 256'(0));
        end else begin
          check("wr_beat", 256'(bmem_wdata), 256'(exp_q[0]));
          if (bmem_ready) begin
            void'(exp_q.pop_front());
            beats_acc++;
            if (first_beat_cycle < 0) first_beat_cycle = cyc;
          end
        end
      end
      if (dfp_resp) begin
        resp_cycle = cyc;
        done = 1;
        if (is_wr) begin
          check("wr_all_beats", 256'(exp_q.size()), 256'(0));
          check("wr_no_read", 256'(saw_read), 256'(0));
          model_wr++;
        end else begin
          check("rd_line", dfp_rdata, rline);
          model_rd++;
        end
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
      end
    end
    if (!done) begin
      check("txn_timeout", 256'(1), 256'(0));
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
    end
    step();
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'($urandom_range(0, 1));
    bmem_rdata  = {$urandom, $urandom};
    check("resp_one_cycle", 256'(dfp_resp), 256'(0));
    check("back_to_idle", 256'(dbg_state), 256'(IDLE));
    check("rd_line_cnt", 256'(rd_line_cnt), 256'(exp_cnt(model_rd)));
    check("wr_line_cnt", 256'(wr_line_cnt), 256'(exp_cnt(model_wr)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rc;
    int fb;
    logic [255:0] line;
    logic [255:0] rline;

    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset state
    step(); step();
    check("rst_resp", 256'(dfp_resp), 256'(0));
    check("rst_bmem_read", 256'(bmem_read), 256'(0));
    check("rst_bmem_write", 256'(bmem_write), 256'(0));
    check("rst_rdata", dfp_rdata, 256'(0));
    check("rst_wdata", 256'(bmem_wdata), 256'(0));
    check("rst_addr", 256'(bmem_addr), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(IDLE));
    check("rst_rd_cnt", 256'(rd_line_cnt), 256'(0));
    check("rst_wr_cnt", 256'(wr_line_cnt), 256'(0));
    step();
    rst = 1'b0;

    // Minimum-latency write at 0x1234, beats k+1 times 0x1111...
    for (int k = 0; k < 4; k++) line[k*64 +: 64] = 64'h1111_1111_1111_1111 * (k + 1);
    run_txn(1, 0, 32'h0000_1234, line, '0, 100, 100, -1, rc, fb);
    check("wr_first_beat_cycle", 256'(fb), 256'(1));
    check("wr_resp_cycle", 256'(rc), 256'(5));

    // Minimum-latency read at 0x8000_0040 with A0..A3 beat patterns
    rline = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
             64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    run_txn(0, 1, 32'h8000_0040, rand_line(), rline, 100, 100, -1, rc, fb);
    check("rd_resp_cycle", 256'(rc), 256'(6));

    // Write with ready held low for 3 cycles in front of beat 2
    run_txn(1, 0, 32'h0000_2000, rand_line(), '0, 100, 100, 2, rc, fb);
    check("stall_first_beat_cycle", 256'(fb), 256'(1));
    check("stall_resp_cycle", 256'(rc), 256'(8));

    // Read and write together: write wins, no read command appears
    run_txn(1, 1, 32'h0000_0040, rand_line(), '0, 100, 100, -1, rc, fb);
    check("both_resp_cycle", 256'(rc), 256'(5));

    // Reset in the middle of a read burst, after beat 1
    rline = rand_line();
    dfp_addr = 32'h0000_0100; dfp_read = 1'b1; bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    step();
    check("rstmid_cmd", 256'(bmem_read), 256'(1));
    step();
    bmem_rvalid = 1'b1; bmem_rdata = rline[63:0];
    step();
    bmem_rdata = rline[127:64];
    step();
    rst = 1'b1; dfp_read = 1'b0; bmem_rdata = rline[191:128];
    step();
    rst = 1'b0; bmem_rdata = rline[255:192];
    model_rd = 0;
    model_wr = 0;
    check("rstmid_state", 256'(dbg_state), 256'(IDLE));
    check("rstmid_no_resp", 256'(dfp_resp), 256'(0));
    check("rstmid_no_cmd", 256'(bmem_read), 256'(0));
    step();
    bmem_rvalid = 1'b0;
    check("rstmid_no_resp_late", 256'(dfp_resp), 256'(0));
    check("rstmid_rdata_clear", dfp_rdata, 256'(0));
    run_txn(0, 1, 32'h0000_0100, rand_line(), rline, 100, 100, -1, rc, fb);
    check("rstmid_next_resp_cycle", 256'(rc), 256'(6));

    // Three reads and two writes after the reset: counters track them
    for (int i = 0; i < 5; i++)
      run_txn(i >= 3, i < 3, $urandom, rand_line(), rand_line(), 100, 100, -1, rc, fb);

    // Randomized traffic with back-pressure and sparse read beats
    for (int i = 0; i < 30; i++) begin
      int op;
      op = $urandom_range(0, 2);
      run_txn(op != 1, op != 0, $urandom, rand_line(), rand_line(),
              $urandom_range(30, 100), $urandom_range(30, 100), -1, rc, fb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
